ascon_output_serializer: RTL
============================

ASCON_OUTPUT_SERIALIZER -- requirements
Module: ascon_output_serializer

Interface
REQ-001 SHALL have parameter: TAG_FIRST, default 0, 0 = ciphertext words sent before tag words, 1 = tag words sent first.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ciphertext  input  128  encryption result from the upstream encrypt core.
REQ-005 SHALL have port: tag  input  128  authentication tag from the upstream encrypt core.
REQ-006 SHALL have port: encrypt_done  input  1  level-high completion flag from the upstream core.
REQ-007 SHALL have port: dout  output  32  serialized output word.
REQ-008 SHALL have port: dout_valid  output  1  dout holds a valid word.
REQ-009 SHALL have port: dout_ready  input  1  downstream accepts a word when high together with dout_valid.
REQ-010 SHALL have port: dout_last  output  1  current word is the final word of the frame.
REQ-011 SHALL have port: busy  output  1  frame capture or transmission in progress.
REQ-012 SHALL have port: overrun  output  1  sticky flag: a completion was dropped.
REQ-013 SHALL have port: clear  input  1  synchronous clear of overrun and abort of any frame.

Function
REQ-014 SHALL register encrypt_done each cycle; start event = encrypt_done high while the registered copy is low (rising edge).
REQ-015 SHALL have states IDLE and SEND only.
REQ-016 In IDLE, on a start event SHALL capture ciphertext and tag into a 256-bit frame register on that edge, clear the word counter, and enter SEND.
REQ-017 dout_valid SHALL be high in the cycle after the start-event edge (1-cycle latency) and remain high throughout SEND.
REQ-018 Frame order SHALL be 8 words, each 128-bit field MSW first: TAG_FIRST=0 -> ct[127:96], ct[95:64], ct[63:32], ct[31:0], tag[127:96] ... tag[31:0]; TAG_FIRST=1 -> tag words then ct words.
REQ-019 A transfer SHALL occur only on a rising edge with dout_valid and dout_ready both high; the 3-bit word counter SHALL advance by 1 per transfer.
REQ-020 While dout_valid is high and dout_ready is low, dout and dout_last SHALL stay stable.
REQ-021 dout_last SHALL be high exactly when word counter = 7 in SEND.
REQ-022 On transfer of word 7 SHALL return to IDLE; dout_valid low the next cycle; counter does not wrap into a second frame.
REQ-023 busy SHALL equal (state == SEND).
REQ-024 A start event while in SEND SHALL not disturb the current frame, SHALL be discarded, and SHALL set overrun.
REQ-025 A start event in the same cycle as the word-7 transfer SHALL be treated as occurring in SEND (discarded, overrun set).
REQ-026 encrypt_done held high across frames SHALL not retrigger; a new frame requires a low-then-high transition.
REQ-027 clear high SHALL, on the next edge, force IDLE, deassert dout_valid, clear overrun and counter; clear takes priority over start event and transfer.
REQ-028 dout SHALL be 0 whenever dout_valid is low.

Reset
REQ-029 While rst_n is low: state IDLE, counter 0, frame register 0, registered encrypt_done 0, dout 0, dout_valid 0, dout_last 0, busy 0, overrun 0.
REQ-030 Reset assertion mid-frame SHALL abort immediately (asynchronously); after release, no frame resumes and encrypt_done already high SHALL produce a start event (registered copy is 0).

Verification
REQ-031 TAG_FIRST=0, ct=0x00112233_44556677_8899AABB_CCDDEEFF, tag=0x01020304_05060708_090A0B0C_0D0E0F10, dout_ready=1 -> 8 consecutive words 00112233,44556677,8899AABB,CCDDEEFF,01020304,05060708,090A0B0C,0D0E0F10; dout_last only on 0D0E0F10; valid first seen 1 cycle after done edge.
REQ-032 Same frame, dout_ready toggled 1,0,0,1,... -> same 8-word sequence, dout stable during stalls, total transfers exactly 8.
REQ-033 Second encrypt_done rising edge during word 3 -> frame completes unchanged, overrun=1 afterwards, no second frame; clear pulse -> overrun=0.
REQ-034 encrypt_done held high 40 cycles -> exactly one frame emitted.
REQ-035 rst_n low during word 5 -> dout_valid=0, busy=0 immediately; release with encrypt_done=1 -> fresh frame from word 0.
REQ-036 TAG_FIRST=1, same vectors as REQ-031 -> first word 01020304, dout_last on CCDDEEFF.

Source files
------------

// File: rtl/ascon_output_serializer.sv
// ascon_output_serializer
// Captures a 128-bit ciphertext and 128-bit tag from the encrypt core when
// encrypt_done rises, then streams them out as eight 32-bit words, MSW first.
// Handshake: a word moves on a rising clk edge where dout_valid and dout_ready
// are both high; while dout_valid is high and dout_ready is low, dout and
// dout_last hold their value; dout_valid never drops without a transfer
// except on clear or reset.
module ascon_output_serializer #(
   parameter int TAG_FIRST = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] ciphertext,
   input  logic [127:0] tag,
   input  logic         encrypt_done,
   output logic [31:0]  dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         dout_last,
   output logic         busy,
   output logic         overrun,
   input  logic         clear
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]   state;
   logic [2:0]   word_cnt;
   logic [255:0] frame;
   logic         done_q;
   logic         start;
   logic         xfer;
   logic [255:0] frame_in;

   // The word on dout always sits in the top 32 bits of the frame register;
   // each transfer shifts the next word up, so the output is a plain slice.
   assign frame_in   = (TAG_FIRST != 0) ? {tag, ciphertext} : {ciphertext, tag};
   assign start      = encrypt_done & ~done_q;
   assign dout_valid = (state == SEND);
   assign xfer       = dout_valid & dout_ready;
   assign dout       = dout_valid ? frame[255:224] : 32'd0;
   assign dout_last  = dout_valid && (word_cnt == 3'd7);
   assign busy       = (state == SEND);

   // Edge detect, frame capture, word sequencing and the sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         word_cnt <= 3'd0;
         frame    <= 256'd0;
         done_q   <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         // Tracked even during clear so a level held through clear cannot
         // later masquerade as a new completion.
         done_q <= encrypt_done;
         if (clear) begin
            state    <= IDLE;
            word_cnt <= 3'd0;
            overrun  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     frame    <= frame_in;
                     word_cnt <= 3'd0;
                     state    <= SEND;
                  end
               end
               SEND: begin
                  // A completion arriving mid-frame (including on the final
                  // transfer) is dropped; the frame in flight is untouched.
                  if (start) begin
                     overrun <= 1'b1;
                  end
                  if (xfer) begin
                     frame <= {frame[223:0], 32'd0};
                     if (word_cnt == 3'd7) begin
                        state    <= IDLE;
                        word_cnt <= 3'd0;
                     end else begin
                        word_cnt <= word_cnt + 3'd1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
